// File: rtl/bilin_pkg.sv
// rtl/bilin_pkg.sv - shared types and constants for the bilinear downscaler
package bilin_pkg;

    localparam int FRAC_BITS = 8;

    // Unsigned fixed point: 8 integer bits, 8 fraction bits.
    typedef logic [15:0] q8_8_t;

    typedef enum logic [3:0] {
        IDLE,
        A00,
        A01,
        A10,
        A11,
        C11,
        CALC,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/bilin_lerp.sv
// rtl/bilin_lerp.sv - combinational two-tap interpolation with a Q0.8 weight
module bilin_lerp
    import bilin_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0]           a,
    input  logic [IN_W-1:0]           b,
    input  logic [FRAC_BITS-1:0]      frac,
    output logic [IN_W+FRAC_BITS:0]   y
);

    localparam int OW = IN_W + FRAC_BITS + 1;
    typedef logic [OW-1:0] wide_t;

    logic [FRAC_BITS:0] w0;

    // Weight of tap a is (1.0 - frac), which needs one extra bit to hold 1.0.
    assign w0 = {1'b1, {FRAC_BITS{1'b0}}} - {1'b0, frac};
    assign y  = wide_t'(a) * wide_t'(w0) + wide_t'(b) * wide_t'(frac);

endmodule

// File: rtl/bilinear_downscaler.sv
// rtl/bilinear_downscaler.sv - frame bilinear downscaler sharing one byte-wide SRAM port
module bilinear_downscaler
    import bilin_pkg::*;
#(
    parameter int SRC_W    = 16,
    parameter int SRC_H    = 8,
    parameter int DST_W    = 8,
    parameter int DST_H    = 4,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] step_x,
    input  logic [15:0] step_y,
    output logic        busy,
    output logic        done,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out
);

    localparam int OXW = (DST_W > 1) ? $clog2(DST_W) : 1;
    localparam int OYW = (DST_H > 1) ? $clog2(DST_H) : 1;
    localparam logic [15:0] XMAX = 16'(SRC_W - 1);
    localparam logic [15:0] YMAX = 16'(SRC_H - 1);

    state_t         state, next_state;
    q8_8_t          sx, sy;
    logic [23:0]    x_acc, y_acc;
    logic [OXW-1:0] ox;
    logic [OYW-1:0] oy;
    logic [7:0]     p00, p01, p10, p11, result;
    logic [7:0]     x0, x1, y0, y1, fx, fy;
    logic [7:0]     src_col, src_row, src_addr, dst_addr;
    logic [16:0]    top_v, bot_v;
    logic [25:0]    vert_v, vert_rnd;
    logic           last_col, last_pix;

    // Neighbour coordinates; once the integer part reaches the edge both taps
    // collapse onto the edge pixel and the fraction is dropped.
    always_comb begin
        if (x_acc[23:8] >= XMAX) begin
            x0 = XMAX[7:0];
            x1 = XMAX[7:0];
            fx = '0;
        end else begin
            x0 = x_acc[15:8];
            x1 = x_acc[15:8] + 8'd1;
            fx = x_acc[7:0];
        end
        if (y_acc[23:8] >= YMAX) begin
            y0 = YMAX[7:0];
            y1 = YMAX[7:0];
            fy = '0;
        end else begin
            y0 = y_acc[15:8];
            y1 = y_acc[15:8] + 8'd1;
            fy = y_acc[7:0];
        end
    end

    always_comb begin
        src_col = x0;
        src_row = y0;
        case (state)
            A01:     src_col = x1;
            A10:     src_row = y1;
            A11: begin
                src_col = x1;
                src_row = y1;
            end
            default: ;
        endcase
    end

    assign src_addr = 8'(SRC_BASE) + src_row * 8'(SRC_W) + src_col;
    assign dst_addr = 8'(DST_BASE) + 8'(oy) * 8'(DST_W) + 8'(ox);
    assign last_col = (ox == OXW'(DST_W - 1));
    assign last_pix = last_col && (oy == OYW'(DST_H - 1));

    bilin_lerp #(.IN_W(8)) u_lerp_top (
        .a(p00), .b(p01), .frac(fx), .y(top_v)
    );

    bilin_lerp #(.IN_W(8)) u_lerp_bot (
        .a(p10), .b(p11), .frac(fx), .y(bot_v)
    );

    bilin_lerp #(.IN_W(17)) u_lerp_vert (
        .a(top_v), .b(bot_v), .frac(fy), .y(vert_v)
    );

    // Add one half in Q.16 so the final shift rounds half up.
    assign vert_rnd = vert_v + 26'd32768;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        busy        = 1'b1;
        done        = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = A00;
            end
            A00: begin
                mem_addr   = src_addr;
                next_state = A01;
            end
            A01: begin
                mem_addr   = src_addr;
                next_state = A10;
            end
            A10: begin
                mem_addr   = src_addr;
                next_state = A11;
            end
            A11: begin
                mem_addr   = src_addr;
                next_state = C11;
            end
            C11:  next_state = CALC;
            CALC: next_state = WRITE;
            WRITE: begin
                mem_we      = 1'b1;
                mem_addr    = dst_addr;
                mem_data_in = result;
                next_state  = last_pix ? DONE : A00;
            end
            DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    // Read data arrives one cycle after its address, so each capture lags the
    // state that presented the address by one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx     <= '0;
            sy     <= '0;
            x_acc  <= '0;
            y_acc  <= '0;
            ox     <= '0;
            oy     <= '0;
            p00    <= '0;
            p01    <= '0;
            p10    <= '0;
            p11    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sx    <= step_x;
                        sy    <= step_y;
                        x_acc <= '0;
                        y_acc <= '0;
                        ox    <= '0;
                        oy    <= '0;
                    end
                end
                A01:  p00 <= mem_data_out;
                A10:  p01 <= mem_data_out;
                A11:  p10 <= mem_data_out;
                C11:  p11 <= mem_data_out;
                CALC: result <= 8'(vert_rnd >> 16);
                WRITE: begin
                    if (last_col) begin
                        ox    <= '0;
                        x_acc <= '0;
                        oy    <= oy + 1'b1;
                        y_acc <= y_acc + 24'(sy);
                    end else begin
                        ox    <= ox + 1'b1;
                        x_acc <= x_acc + 24'(sx);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bilinear_downscaler.sv
// tb/tb_bilinear_downscaler.sv - self-checking bench for bilinear_downscaler
module tb_bilinear_downscaler;

    localparam int SRC_W    = 16;
    localparam int SRC_H    = 8;
    localparam int DST_W    = 8;
    localparam int DST_H    = 4;
    localparam int SRC_BASE = 0;
    localparam int DST_BASE = 128;
    localparam int NPIX     = DST_W * DST_H;
    localparam int LAT      = 7 * NPIX + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] step_x, step_y;
    logic        busy, done, mem_we;
    logic [7:0]  mem_addr, mem_data_in;
    logic [7:0]  mem_data_out = 8'h00;

    logic [7:0]  src_mem [0:255];
    logic [7:0]  wr_addr [$];
    logic [7:0]  wr_data [$];
    int          done_cnt = 0;
    int          read_oob = 0;
    int          exp_data [NPIX];
    int          row038 [DST_W] = '{0, 2, 3, 5, 6, 8, 9, 11};
    int          row039 [DST_W] = '{0, 3, 6, 9, 12, 15, 15, 15};
    int          checks = 0;
    int          errors = 0;

    bilinear_downscaler #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H),
        .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .step_x(step_x), .step_y(step_y),
        .busy(busy), .done(done), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: read data valid the cycle after the address.
    always @(posedge clk) mem_data_out <= src_mem[mem_addr];

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data_in);
        end
        if (done) done_cnt++;
        if (busy && !mem_we && mem_addr >= 8'(DST_BASE)) read_oob++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // mode 0: flat 0x55, 1: pixel = x, 2: random
    task automatic fill(input int mode);
        for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
        for (int y = 0; y < SRC_H; y++)
            for (int x = 0; x < SRC_W; x++)
                src_mem[SRC_BASE + y * SRC_W + x] =
                    (mode == 0) ? 8'h55 : (mode == 1) ? 8'(x) : 8'($urandom_range(0, 255));
    endtask

    function automatic int pix(input int x, input int y);
        return int'(src_mem[SRC_BASE + y * SRC_W + x]);
    endfunction

    // Plain-arithmetic reference for a whole frame.
    function automatic void build_expected(input int sx, input int sy);
        int xi, yi, x1, y1, fx, fy, top, bot;
        for (int oy = 0; oy < DST_H; oy++) begin
            for (int ox = 0; ox < DST_W; ox++) begin
                xi = (ox * sx) / 256;  fx = (ox * sx) % 256;
                yi = (oy * sy) / 256;  fy = (oy * sy) % 256;
                if (xi >= SRC_W - 1) begin xi = SRC_W - 1; x1 = xi; fx = 0; end
                else x1 = xi + 1;
                if (yi >= SRC_H - 1) begin yi = SRC_H - 1; y1 = yi; fy = 0; end
                else y1 = yi + 1;
                top = pix(xi, yi) * (256 - fx) + pix(x1, yi) * fx;
                bot = pix(xi, y1) * (256 - fx) + pix(x1, y1) * fx;
                exp_data[oy * DST_W + ox] = (top * (256 - fy) + bot * fy + 32768) / 65536;
            end
        end
    endfunction

    // Caller sits #1 after a rising edge; lat counts edges from start high to done high.
    task automatic run_frame(input logic [15:0] sx, input logic [15:0] sy,
                             input int poke, output int lat);
        step_x = sx;
        step_y = sy;
        start  = 1'b1;
        lat    = -1;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk); #1;
            start = (poke != 0) && (n == poke || n == poke + 60);
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        step_x = 16'h0;
        step_y = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", mem_addr); end
        checks++; if (mem_data_in !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", mem_data_in); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_flat();
        int lat, w0, d0;
        fill(0);
        w0 = wr_addr.size(); d0 = done_cnt;
        run_frame(16'h0200, 16'h0200, 0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL flat_latency got %0d want %0d", lat, LAT); end
        checks++; if (wr_addr.size() - w0 !== NPIX) begin errors++; $display("FAIL flat_count got %0d want %0d", wr_addr.size() - w0, NPIX); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL flat_done got %0d want 1", done_cnt - d0); end
        if (wr_addr.size() - w0 == NPIX)
            for (int i = 0; i < NPIX; i++) begin
                checks++;
                if (wr_addr[w0 + i] !== 8'(DST_BASE + i) || wr_data[w0 + i] !== 8'h55) begin
                    errors++;
                    $display("FAIL flat_px%0d got %0d:%h want %0d:55", i, wr_addr[w0 + i], wr_data[w0 + i], DST_BASE + i);
                end
            end
    endtask

    // Ramp source; every row is identical so each output row matches one table.
    task automatic test_ramp(input string name, input logic [15:0] sx, input logic [15:0] sy, input int which);
        int lat, w0, want;
        fill(1);
        w0 = wr_addr.size(); read_oob = 0;
        run_frame(sx, sy, 0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, LAT); end
        checks++; if (wr_addr.size() - w0 !== NPIX) begin errors++; $display("FAIL %s_count got %0d want %0d", name, wr_addr.size() - w0, NPIX); end
        checks++; if (read_oob !== 0) begin errors++; $display("FAIL %s_read_range got %0d bad reads want 0", name, read_oob); end
        if (wr_addr.size() - w0 == NPIX)
            for (int i = 0; i < NPIX; i++) begin
                want = (which == 0) ? 2 * (i % DST_W) : (which == 1) ? row038[i % DST_W] : row039[i % DST_W];
                checks++;
                if (wr_addr[w0 + i] !== 8'(DST_BASE + i) || int'(wr_data[w0 + i]) !== want) begin
                    errors++;
                    $display("FAIL %s_px%0d got %0d:%0d want %0d:%0d", name, i, wr_addr[w0 + i], wr_data[w0 + i], DST_BASE + i, want);
                end
            end
    endtask

    task automatic test_random();
        int lat, w0;
        logic [15:0] sx, sy;
        for (int r = 0; r < 4; r++) begin
            fill(2);
            sx = 16'($urandom_range(0, 16'h0400));
            sy = 16'($urandom_range(0, 16'h0300));
            build_expected(int'(sx), int'(sy));
            w0 = wr_addr.size();
            run_frame(sx, sy, 0, lat);
            checks++; if (wr_addr.size() - w0 !== NPIX) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", r, wr_addr.size() - w0, NPIX); end
            if (wr_addr.size() - w0 == NPIX)
                for (int i = 0; i < NPIX; i++) begin
                    checks++;
                    if (wr_addr[w0 + i] !== 8'(DST_BASE + i) || int'(wr_data[w0 + i]) !== exp_data[i]) begin
                        errors++;
                        $display("FAIL rand%0d_px%0d sx=%h sy=%h got %0d:%0d want %0d:%0d", r, i, sx, sy,
                                 wr_addr[w0 + i], wr_data[w0 + i], DST_BASE + i, exp_data[i]);
                    end
                end
        end
    endtask

    task automatic test_reset_abort();
        int lat, w0, d0, w1;
        fill(1);
        w0 = wr_addr.size(); d0 = done_cnt;
        step_x = 16'h0200; step_y = 16'h0200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        checks++; if (wr_addr.size() - w0 !== 5) begin errors++; $display("FAIL abort_pre_writes got %0d want 5", wr_addr.size() - w0); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_we got %b want 0", mem_we); end
        checks++; if (wr_addr.size() - w0 !== 5) begin errors++; $display("FAIL abort_writes got %0d want 5", wr_addr.size() - w0); end
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt - d0); end
        w1 = wr_addr.size();
        run_frame(16'h0200, 16'h0200, 0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL abort_restart_latency got %0d want %0d", lat, LAT); end
        checks++; if (wr_addr.size() - w1 !== NPIX) begin errors++; $display("FAIL abort_restart_count got %0d want %0d", wr_addr.size() - w1, NPIX); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL abort_restart_done got %0d want 1", done_cnt - d0); end
        if (wr_addr.size() - w1 == NPIX) begin
            checks++;
            if (wr_data[w1 + NPIX - 1] !== 8'd14 || wr_addr[w1] !== 8'(DST_BASE)) begin
                errors++;
                $display("FAIL abort_restart_data got %0d@%0d want 14@%0d", wr_data[w1 + NPIX - 1], wr_addr[w1], DST_BASE);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, w0, d0;
        fill(1);
        w0 = wr_addr.size(); d0 = done_cnt;
        run_frame(16'h0200, 16'h0200, 50, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", lat, LAT); end
        checks++; if (wr_addr.size() - w0 !== NPIX) begin errors++; $display("FAIL busy_start_count got %0d want %0d", wr_addr.size() - w0, NPIX); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_start_done got %0d want 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_ramp("ramp2x", 16'h0200, 16'h0200, 0);
        test_ramp("ramp1p5", 16'h0180, 16'h0000, 1);
        test_ramp("clamp", 16'h0300, 16'h0200, 2);
        test_random();
        test_reset_abort();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
